// File: rtl/mem_bus_arbiter_pkg.sv
// Shared cpu0 definitions: operand width codes, default memory limit, arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

  // Operand width codes carried on size0/size1 and m_size.
  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    INT16 = 2'b01,
    INT24 = 2'b10,
    INT32 = 2'b11
  } size_e;

  // First illegal byte address of the memory.
  localparam logic [31:0] MEM_LIMIT_DEF = 32'h0000_7000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // A word access at addr is legal only if all four bytes lie below limit.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input logic [31:0] limit);
    return addr > (limit - 32'd4);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of master request/response signals and the memory port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: level req held by each master until its done pulse.
// Ports: req/rw/size/addr/wdata per master in, gnt/done/err per master out,
//        rdata out, m_en/m_rw/m_size/mar/mdr to memory, dbus from memory.
interface mem_bus_arbiter_if;

  logic        req0, req1;
  logic        rw0, rw1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic        err0, err1;
  logic [31:0] rdata;
  logic        m_en, m_rw;
  logic [1:0]  m_size;
  logic [31:0] mar, mdr;
  logic [31:0] dbus;

  // Arbiter side.
  modport slave (
    input  req0, req1, rw0, rw1, size0, size1, addr0, addr1, wdata0, wdata1, dbus,
    output gnt0, gnt1, done0, done1, err0, err1, rdata, m_en, m_rw, m_size, mar, mdr
  );

  // Bus masters plus the memory that drives dbus.
  modport master (
    output req0, req1, rw0, rw1, size0, size1, addr0, addr1, wdata0, wdata1, dbus,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata, m_en, m_rw, m_size, mar, mdr
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-input round-robin select: lone request wins, a tie goes to the non-last master.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: i_req0/i_req1 requests, i_last_grant previous owner, o_winner/o_valid result.
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_winner,
  output logic o_valid
);

  assign o_valid  = i_req0 | i_req1;
  assign o_winner = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU/DMA) memory port arbiter with round-robin and address range check.
// Latency: done ACCESS_CYCLES+1 cycles after the request is sampled; one idle cycle between transfers.
// Backpressure: requests are only sampled in IDLE; masters hold req until their done pulse.
// Ports: clock, reset (sync, active low), bus (slave modport of mem_bus_arbiter_if).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter logic [31:0] MEM_LIMIT     = MEM_LIMIT_DEF
) (
  input logic              clock,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  arb_state_e  r_state;
  logic        r_last_grant;
  logic        r_owner;
  logic [3:0]  r_cnt;
  logic        r_gnt0, r_gnt1;
  logic        r_done0, r_done1;
  logic        r_err0, r_err1;
  logic [31:0] r_rdata;
  logic        r_m_en, r_m_rw;
  logic [1:0]  r_m_size;
  logic [31:0] r_mar, r_mdr;

  logic        w_winner, w_valid;
  logic        w_sel_rw;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr, w_sel_wdata;
  logic        w_sel_oob;

  rr_pick2 u_pick (
    .i_req0       (bus.req0),
    .i_req1       (bus.req1),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_valid      (w_valid)
  );

  // Attributes of whichever master wins this cycle.
  assign w_sel_rw    = w_winner ? bus.rw1    : bus.rw0;
  assign w_sel_size  = w_winner ? bus.size1  : bus.size0;
  assign w_sel_addr  = w_winner ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_winner ? bus.wdata1 : bus.wdata0;
  assign w_sel_oob   = addr_out_of_range(w_sel_addr, MEM_LIMIT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= 4'd0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata      <= 32'd0;
      r_m_en       <= 1'b0;
      r_m_rw       <= 1'b1;
      r_m_size     <= INT32;
      r_mar        <= 32'd0;
      r_mdr        <= 32'd0;
    end else begin
      // done/err are single-cycle pulses, raised only on entry to RESP.
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_m_rw       <= w_sel_rw;
            r_m_size     <= w_sel_size;
            r_mar        <= w_sel_addr;
            r_mdr        <= w_sel_wdata;
            r_gnt0       <= ~w_winner;
            r_gnt1       <= w_winner;
            r_last_grant <= w_winner;
            r_owner      <= w_winner;
            r_cnt        <= CNT_INIT;
            if (w_sel_oob) begin
              // Illegal address: skip the memory entirely and answer at once.
              r_m_en  <= 1'b0;
              r_rdata <= 32'd0;
              r_done0 <= ~w_winner;
              r_done1 <= w_winner;
              r_err0  <= ~w_winner;
              r_err1  <= w_winner;
              r_state <= ST_RESP;
            end else begin
              r_m_en  <= 1'b1;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_m_rw) begin
              r_rdata <= bus.dbus;
            end
            r_m_en  <= 1'b0;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt0   = r_gnt0;
  assign bus.gnt1   = r_gnt1;
  assign bus.done0  = r_done0;
  assign bus.done1  = r_done1;
  assign bus.err0   = r_err0;
  assign bus.err1   = r_err1;
  assign bus.rdata  = r_rdata;
  assign bus.m_en   = r_m_en;
  assign bus.m_rw   = r_m_rw;
  assign bus.m_size = r_m_size;
  assign bus.mar    = r_mar;
  assign bus.mdr    = r_mdr;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 1: cycles m_en is held per transfer (1..15).
REQ-002 Parameter MEM_LIMIT, default 'h7000: first illegal byte address; legal addresses are 0..MEM_LIMIT-4.
REQ-003 clock  input  1  sole clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req0, req1  input  1 each  transfer request, master 0 (CPU) / master 1 (DMA).
REQ-006 rw0, rw1  input  1 each  1 = read, 0 = write.
REQ-007 size0, size1  input  2 each  operand width: 11 INT32, 10 INT24, 01 INT16, 00 BYTE.
REQ-008 addr0, addr1  input  32 each  byte address.
REQ-009 wdata0, wdata1  input  32 each  write data.
REQ-010 gnt0, gnt1  output  1 each  master owns the memory port.
REQ-011 done0, done1  output  1 each  one-cycle transfer-complete pulse.
REQ-012 err0, err1  output  1 each  one-cycle pulse with done for an out-of-range address.
REQ-013 rdata  output  32  captured read data, valid while doneN=1.
REQ-014 m_en, m_rw  output  1 each  memory enable / read-not-write.
REQ-015 m_size  output  2  memory operand width.
REQ-016 mar, mdr  output  32 each  memory address / write data.
REQ-017 dbus  input  32  memory read data, combinational from the memory.

Function
REQ-018 The FSM has three states: IDLE, BUSY and RESP, plus the 1-bit last_grant register.
REQ-019 In IDLE, sampled requests select a winner as follows: a single request wins; with both asserted, the master other than last_grant wins.
REQ-020 On IDLE with a winner, the block latches {rw,size,addr,wdata} into m_rw/m_size/mar/mdr and sets gntN=1, last_grant=N, cnt=ACCESS_CYCLES-1.
REQ-021 In the same IDLE-with-winner cycle, the block moves to BUSY with m_en=1, or to RESP with m_en=0 when addr > MEM_LIMIT-4.
REQ-022 In BUSY, while cnt!=0 the block decrements cnt.
REQ-023 In BUSY, at cnt==0 the block captures rdata=dbus on reads (rdata unchanged on writes), drops m_en, and moves to RESP.
REQ-024 In RESP, the block pulses doneN (and errN if the address was out of range), holds rdata, clears gntN, and returns to IDLE.
REQ-025 Out-of-range transfers never assert m_en and return rdata=0.
REQ-026 Latency: for a request sampled at edge T with ACCESS_CYCLES=1, m_en is high during cycle T+1 and doneN is high during cycle T+2.
REQ-027 Latency in general is done at edge T+1+ACCESS_CYCLES; the minimum spacing is 2+ACCESS_CYCLES cycles per transfer.
REQ-028 Handshake: a master holds req and all attributes stable from assertion until its doneN, and may deassert or re-assert req in the done cycle.
REQ-029 Requests are ignored in BUSY and RESP, with no queuing beyond the level req.
REQ-030 A request still asserted when the block returns to IDLE is arbitrated anew, so round-robin alternates under continuous dual requests.
REQ-031 gnt0 and gnt1 are never both 1; done0 and done1 are never both 1.
REQ-032 m_rw/m_size/mar/mdr hold their last values when m_en=0.
REQ-033 The block ignores a change of req or attributes by the granted master during BUSY.

Reset
REQ-034 While reset=0 at a posedge, the block enters IDLE, and gnt*, done*, err* and m_en become 0.
REQ-035 While reset=0 at a posedge, m_rw becomes 1, m_size becomes INT32, and mar, mdr, rdata and cnt become 0.
REQ-036 While reset=0 at a posedge, last_grant becomes 1, so master 0 wins the first tie.
REQ-037 Reset mid-transfer aborts it with no done pulse; m_en is low from the first cycle after the reset edge.

Structure
REQ-038 The shared cpu0 package holds the width codes (INT32/INT24/INT16/BYTE), the MEM_LIMIT default, and the arbiter state enum.
REQ-039 A sub-module rr_pick2 (2-input round-robin select from req0, req1, last_grant to winner and valid) is instantiated once.
REQ-040 The datapath muxes and FSM live in mem_bus_arbiter.

Verification
REQ-041 Scenario: req0 alone, read INT32 at 'h0010 with memory word 'h12345678 -> gnt0 at T+1, m_en=1 with mar='h10 at T+1, done0 with rdata='h12345678 at T+2.
REQ-042 Scenario: req0 and req1 asserted on the same edge after reset, both held -> grant order 0,1,0,1; each done one cycle apart from the next grant plus 2 cycles.
REQ-043 Scenario: req1 write BYTE 'hAB to 'h7000 (MEM_LIMIT) -> m_en stays 0, done1 and err1 pulse together at T+1, rdata=0.
REQ-044 Scenario: ACCESS_CYCLES=3, req0 read -> m_en high exactly 3 cycles, done0 at T+4.
REQ-045 Scenario: reset=0 asserted on the cycle after gnt1 -> no done1, m_en=0, and the next tie is won by master 0.
REQ-046 Scenario: master 0 changes addr0 during BUSY -> mar unchanged, and the transfer completes with the originally latched address.
